clause_scan_controller: RTL and testbench
=========================================

# clause_scan_controller

Sequences a full pass of the clause database through partial-satisfaction evaluation for the SAT solver core. On `start` it streams clause indices to the clause memory one per cycle, classifies each returned clause against the current variable assignment (satisfied, conflict, unit, unresolved, empty), stops early on the first conflict, and reports a single scan verdict to the decision/backtrack FSM.

## Interface
- `VAR_PER_CLAUSE`, 5, literal slots per clause
- `NUM_CLAUSES`, 16, clauses in the database (≥2)
- `CIDX_W`, $clog2(NUM_CLAUSES), clause index width
- `SLOT_W`, $clog2(VAR_PER_CLAUSE), slot index width
- `clock`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin scan; honoured only in IDLE
- `abort`  in  1  cancel scan; returns to IDLE, no `done`
- `clause_rd_en`  out  1  clause/assignment read request
- `clause_rd_addr`  out  CIDX_W  clause index being read
- `clause_mask`  in  VAR_PER_CLAUSE  slot used (valid 1 cycle after request)
- `clause_pole`  in  VAR_PER_CLAUSE  1 = negated literal
- `var_assigned`  in  VAR_PER_CLAUSE  1 = slot variable assigned
- `var_val`  in  VAR_PER_CLAUSE  assigned value
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse, verdict valid
- `result`  out  2  00 UNDECIDED, 01 ALL_SAT, 10 UNIT, 11 CONFLICT
- `conflict_idx`  out  CIDX_W  first conflicting clause
- `unit_idx`  out  CIDX_W  first unit clause
- `unit_slot`  out  SLOT_W  free slot of that unit clause

## Operation
- States: IDLE, SCAN, DRAIN, REPORT.
- IDLE: `start`=1 & `abort`=0 → SCAN; clear clause counter, sticky flags, captured indices.
- SCAN: `clause_rd_en`=1, `clause_rd_addr` = 0,1,…,NUM_CLAUSES-1 on consecutive cycles. After issuing NUM_CLAUSES-1 → DRAIN (rd_en=0).
- Response for index k is evaluated the cycle after its request (1-cycle read latency, fixed, no backpressure).
- Per clause: lit_true = mask & assigned & (val ^ pole); free = mask & ~assigned.
  - mask==0: empty, ignored (counts neither sat nor unsat).
  - |lit_true: satisfied.
  - else free==0: CONFLICT → capture `conflict_idx`=k, stop issuing, discard in-flight response, → REPORT.
  - else popcount(free)==1: unit; if first unit, capture `unit_idx`=k, `unit_slot` = index of the free bit; set unit flag.
  - else unresolved; clear all_sat flag.
- DRAIN: evaluate last response (same rules) → REPORT.
- REPORT: `done`=1 for one cycle, `result` = CONFLICT if conflict, else UNIT if unit flag, else ALL_SAT if no unsatisfied non-empty clause, else UNDECIDED → IDLE.
- `result`, `conflict_idx`, `unit_idx`, `unit_slot` hold until next accepted `start`; index outputs are 0 when not applicable.
- `abort` in SCAN/DRAIN/REPORT: → IDLE next edge, `done` suppressed, `result` forced 00. `abort` beats `start` in IDLE.
- `start` outside IDLE ignored.
- `reset_n` low at any time: immediate IDLE; all outputs 0 (busy, done, rd_en, rd_addr, result, indices).

## Timing
- `start` sampled at edge E0; addr k driven during cycle k+1; its data sampled at E(k+2).
- Full scan: `done` high during cycle NUM_CLAUSES+2.
- Conflict at clause k: `done` high during cycle k+3; addr k+1 may already have been issued, its data ignored.
- `busy`=1 from cycle 1 through the `done` cycle inclusive; 0 the cycle after.
- Back-to-back: `start` may be asserted in the cycle after `done`.

## Test plan
- NUM_CLAUSES=4, all clauses mask 00111 each with one true literal (assigned 00001, val 00001, pole 0) → `done` at cycle 6, result 01, rd_addr sequence 0,1,2,3.
- Clause 1: mask 00111, assigned 00111, val 00000, pole 00000 (all false) → result 11, conflict_idx 1, `done` at cycle 4, no read of addr 3.
- Clause 2: mask 00111, assigned 00101, no true literal; clause 3 same with free slot 4 → result 10, unit_idx 2, unit_slot 1.
- Clause 0 unit, clause 3 conflict → result 11 (conflict priority), conflict_idx 3; all clauses mask 0 → result 01.
- `abort` at cycle 3 → busy 0 at cycle 4, no `done`, result 00; `start` while busy ignored (addr sequence unchanged).
- `reset_n` dropped mid-scan (cycle 2, asynchronous) → all outputs 0 immediately; fresh `start` runs full scan correctly.

Source files
------------

// File: rtl/clause_scan_controller.sv
// Clause scan controller: streams the clause database through partial-satisfaction
// evaluation and reports one verdict (conflict / unit / all-sat / undecided).
module clause_scan_controller #(
    parameter int VAR_PER_CLAUSE = 5,
    parameter int NUM_CLAUSES    = 16,
    parameter int CIDX_W         = $clog2(NUM_CLAUSES),
    parameter int SLOT_W         = $clog2(VAR_PER_CLAUSE)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    output logic                      clause_rd_en,
    output logic [CIDX_W-1:0]         clause_rd_addr,
    input  logic [VAR_PER_CLAUSE-1:0] clause_mask,
    input  logic [VAR_PER_CLAUSE-1:0] clause_pole,
    input  logic [VAR_PER_CLAUSE-1:0] var_assigned,
    input  logic [VAR_PER_CLAUSE-1:0] var_val,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                result,
    output logic [CIDX_W-1:0]         conflict_idx,
    output logic [CIDX_W-1:0]         unit_idx,
    output logic [SLOT_W-1:0]         unit_slot
);

    localparam int CNT_W = $clog2(VAR_PER_CLAUSE + 1);
    localparam logic [CIDX_W-1:0] LAST = CIDX_W'(NUM_CLAUSES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        REPORT
    } state_t;

    state_t state, state_n;

    logic [CIDX_W-1:0] cnt;
    logic [CIDX_W-1:0] pend_idx;
    logic              pend;
    logic              conf_f;
    logic              unit_f;
    logic              unsat_f;

    logic [VAR_PER_CLAUSE-1:0] lit_true;
    logic [VAR_PER_CLAUSE-1:0] free;
    logic [CNT_W-1:0]          free_cnt;
    logic [SLOT_W-1:0]         free_slot;
    logic                      eval_act;
    logic                      eval_conf;
    logic                      eval_unit;
    logic                      eval_open;
    logic                      evaluating;
    logic [1:0]                verdict;

    // Classification of the response returned for pend_idx
    always_comb begin
        lit_true  = clause_mask & var_assigned & (var_val ^ clause_pole);
        free      = clause_mask & ~var_assigned;
        free_cnt  = '0;
        free_slot = '0;
        for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
            if (free[i]) begin
                free_cnt  = free_cnt + 1'b1;
                free_slot = SLOT_W'(i);
            end
        end
        evaluating = pend && (state == SCAN || state == DRAIN);
        eval_act   = evaluating && (|clause_mask) && !(|lit_true);
        eval_conf  = eval_act && !(|free);
        eval_unit  = eval_act && (free_cnt == CNT_W'(1));
        eval_open  = eval_act && (free_cnt > CNT_W'(1));
    end

    always_comb begin
        verdict = 2'b01;
        if (conf_f || eval_conf) begin
            verdict = 2'b11;
        end else if (unit_f || eval_unit) begin
            verdict = 2'b10;
        end else if (unsat_f || eval_open) begin
            verdict = 2'b00;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start && !abort) state_n = SCAN;
            end
            SCAN: begin
                if (abort)            state_n = IDLE;
                else if (eval_conf)   state_n = REPORT;
                else if (cnt == LAST) state_n = DRAIN;
            end
            DRAIN: begin
                state_n = abort ? IDLE : REPORT;
            end
            REPORT: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy           = (state != IDLE);
    assign clause_rd_en   = (state == SCAN);
    assign clause_rd_addr = clause_rd_en ? cnt : '0;
    assign done           = (state == REPORT) && !abort;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            pend         <= 1'b0;
            pend_idx     <= '0;
            conf_f       <= 1'b0;
            unit_f       <= 1'b0;
            unsat_f      <= 1'b0;
            result       <= 2'b00;
            conflict_idx <= '0;
            unit_idx     <= '0;
            unit_slot    <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        cnt          <= '0;
                        pend         <= 1'b0;
                        conf_f       <= 1'b0;
                        unit_f       <= 1'b0;
                        unsat_f      <= 1'b0;
                        result       <= 2'b00;
                        conflict_idx <= '0;
                        unit_idx     <= '0;
                        unit_slot    <= '0;
                    end
                end
                SCAN: begin
                    pend     <= 1'b1;
                    pend_idx <= cnt;
                    if (cnt != LAST) cnt <= cnt + 1'b1;
                end
                default: pend <= 1'b0;
            endcase

            if (eval_conf) begin
                conf_f       <= 1'b1;
                conflict_idx <= pend_idx;
            end
            if (eval_unit && !unit_f) begin
                unit_f    <= 1'b1;
                unit_idx  <= pend_idx;
                unit_slot <= free_slot;
            end
            if (eval_open) unsat_f <= 1'b1;

            // In-flight response after a conflict is dropped
            if (state_n == REPORT) begin
                result <= verdict;
                pend   <= 1'b0;
            end

            if (abort && state != IDLE) begin
                pend         <= 1'b0;
                result       <= 2'b00;
                conflict_idx <= '0;
                unit_idx     <= '0;
                unit_slot    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_clause_scan_controller.sv
// Directed bench for clause_scan_controller with a scoreboard of
// expected verdicts computed from a reference model of the clause memory.
module tb_clause_scan_controller;

    localparam int V  = 5;
    localparam int N  = 4;
    localparam int CW = $clog2(N);
    localparam int SW = $clog2(V);

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic          clause_rd_en;
    logic [CW-1:0] clause_rd_addr;
    logic [V-1:0]  clause_mask;
    logic [V-1:0]  clause_pole;
    logic [V-1:0]  var_assigned;
    logic [V-1:0]  var_val;
    logic          busy;
    logic          done;
    logic [1:0]    result;
    logic [CW-1:0] conflict_idx;
    logic [CW-1:0] unit_idx;
    logic [SW-1:0] unit_slot;

    int checks   = 0;
    int failures = 0;

    logic [V-1:0] mem_m [N];
    logic [V-1:0] mem_a [N];
    logic [V-1:0] mem_v [N];
    logic [V-1:0] mem_p [N];
    int addrs[$];

    typedef struct {
        int res;
        int cidx;
        int uidx;
        int uslot;
        int dcyc;
        int nreads;
    } exp_t;

    exp_t sb[$];

    clause_scan_controller #(
        .VAR_PER_CLAUSE(V),
        .NUM_CLAUSES(N)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .clause_rd_en(clause_rd_en),
        .clause_rd_addr(clause_rd_addr),
        .clause_mask(clause_mask),
        .clause_pole(clause_pole),
        .var_assigned(var_assigned),
        .var_val(var_val),
        .busy(busy),
        .done(done),
        .result(result),
        .conflict_idx(conflict_idx),
        .unit_idx(unit_idx),
        .unit_slot(unit_slot)
    );

    always #5 clock = ~clock;

    // Clause memory with one cycle of read latency
    always @(posedge clock) begin
        if (reset_n && clause_rd_en) begin
            addrs.push_back(int'(clause_rd_addr));
            clause_mask  <= mem_m[clause_rd_addr];
            var_assigned <= mem_a[clause_rd_addr];
            var_val      <= mem_v[clause_rd_addr];
            clause_pole  <= mem_p[clause_rd_addr];
        end else begin
            clause_mask  <= '0;
            var_assigned <= '0;
            var_val      <= '0;
            clause_pole  <= '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_clause(input int k, input logic [V-1:0] m, input logic [V-1:0] a,
                              input logic [V-1:0] v, input logic [V-1:0] p);
        mem_m[k] = m;
        mem_a[k] = a;
        mem_v[k] = v;
        mem_p[k] = p;
    endtask

    task automatic set_all_sat();
        for (int k = 0; k < N; k++) set_clause(k, 5'b00111, 5'b00001, 5'b00001, 5'b00000);
    endtask

    function automatic exp_t model();
        exp_t e;
        logic conf, unit, unsat;
        logic [V-1:0] lt, fr;
        int pc, pos;
        conf = 0; unit = 0; unsat = 0;
        e.cidx = 0; e.uidx = 0; e.uslot = 0;
        e.dcyc = N + 2; e.nreads = N;
        for (int k = 0; k < N; k++) begin
            lt = mem_m[k] & mem_a[k] & (mem_v[k] ^ mem_p[k]);
            fr = mem_m[k] & ~mem_a[k];
            pc = 0; pos = 0;
            for (int i = 0; i < V; i++) if (fr[i]) begin pc++; pos = i; end
            if (mem_m[k] != 0 && lt == 0) begin
                if (pc == 0) begin
                    conf = 1;
                    e.cidx = k;
                    e.dcyc = k + 3;
                    e.nreads = (k + 2 < N) ? k + 2 : N;
                    break;
                end else if (pc == 1) begin
                    if (!unit) begin
                        unit = 1;
                        e.uidx = k;
                        e.uslot = pos;
                    end
                end else begin
                    unsat = 1;
                end
            end
        end
        e.res = conf ? 3 : unit ? 2 : unsat ? 0 : 1;
        return e;
    endfunction

    task automatic run_scan(input string name, input int extra_start);
        exp_t e, g;
        int cyc;
        logic seen;
        e = model();
        sb.push_back(e);
        addrs.delete();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (done) begin
                seen = 1'b1;
                g = sb.pop_front();
                chk({name, "_done_cycle"}, 32'(cyc), 32'(g.dcyc));
                chk({name, "_result"}, 32'(result), 32'(g.res));
                chk({name, "_conflict_idx"}, 32'(conflict_idx), 32'(g.cidx));
                chk({name, "_unit_idx"}, 32'(unit_idx), 32'(g.uidx));
                chk({name, "_unit_slot"}, 32'(unit_slot), 32'(g.uslot));
                chk({name, "_busy_in_done"}, 32'(busy), 32'd1);
            end
            start = (cyc == extra_start);
        end
        start = 1'b0;
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clock);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        chk({name, "_done_after"}, 32'(done), 32'd0);
        chk({name, "_result_hold"}, 32'(result), 32'(e.res));
        chk({name, "_nreads"}, 32'(addrs.size()), 32'(e.nreads));
        for (int i = 0; i < addrs.size(); i++) chk({name, "_addr"}, 32'(addrs[i]), 32'(i));
    endtask

    initial begin
        int dn;
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        set_all_sat();
        repeat (2) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(clause_rd_en), 32'd0);
        chk("rst_rd_addr", 32'(clause_rd_addr), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cidx", 32'(conflict_idx), 32'd0);
        chk("rst_uidx", 32'(unit_idx), 32'd0);
        chk("rst_uslot", 32'(unit_slot), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_scan("allsat", 0);

        set_clause(1, 5'b00111, 5'b00111, 5'b00000, 5'b00000);
        run_scan("conf1", 0);

        set_all_sat();
        set_clause(2, 5'b00111, 5'b00101, 5'b00000, 5'b00000);
        set_clause(3, 5'b10011, 5'b00011, 5'b00000, 5'b00000);
        run_scan("unit2", 0);

        set_all_sat();
        set_clause(0, 5'b00111, 5'b00110, 5'b00000, 5'b00000);
        set_clause(3, 5'b00111, 5'b00111, 5'b00000, 5'b00000);
        run_scan("unitconf", 0);

        for (int k = 0; k < N; k++) set_clause(k, 5'b00000, 5'b11111, 5'b00000, 5'b00000);
        run_scan("empty", 0);

        set_all_sat();
        set_clause(0, 5'b00011, 5'b00001, 5'b00000, 5'b00001);
        set_clause(1, 5'b00111, 5'b00000, 5'b00000, 5'b00000);
        run_scan("undecided", 0);

        set_all_sat();
        run_scan("start_busy", 2);

        // Abort mid-scan: no done, result cleared
        set_all_sat();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        dn = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clock);
            if (done) dn++;
            if (cyc == 3) chk("abort_busy_c3", 32'(busy), 32'd1);
            if (cyc == 4) chk("abort_busy_c4", 32'(busy), 32'd0);
            abort = (cyc == 3);
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        chk("abort_result", 32'(result), 32'd0);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        chk("abort_beats_start", 32'(busy), 32'd0);
        chk("abort_beats_rd_en", 32'(clause_rd_en), 32'd0);
        start = 1'b0;
        abort = 1'b0;

        set_all_sat();
        set_clause(1, 5'b00111, 5'b00101, 5'b00000, 5'b00000);
        run_scan("pre_reset", 0);

        // Asynchronous reset in the middle of a scan
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rd_en", 32'(clause_rd_en), 32'd0);
        chk("arst_rd_addr", 32'(clause_rd_addr), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_uidx", 32'(unit_idx), 32'd0);
        chk("arst_uslot", 32'(unit_slot), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_scan("post_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
